// File: rtl/pipa_counter_req.sv
// pipa_counter_req: PIPA pulse front end for the counter-increment path.
//
// Synchronizes the six raw PIPA pulse lines, keeps one pending count per axis and
// sign, and nets opposing pulses. Pending counts are issued one at a time as
// counter requests (axis + PINC/MINC) over a CTREQ/CTACK handshake. It also raises
// sticky fail (PIPAFL) and lost-count (PIPOVF) alarms.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   PIPA{X,Y,Z}{p,m}         raw pulses, asynchronous to clk
//   CTACK                    counter logic accepts the presented request
//   FLCLR                    clears PIPAFL and PIPOVF
//   CTREQ                    request valid
//   CTAXIS                   0=X, 1=Y, 2=Z
//   CTSIGN                   0=PINC, 1=MINC
//   PIPAFL                   sticky PIPA fail
//   PIPOVF                   sticky lost-count overflow
//
// Pending/event vectors use index axis*2+sign: 0=X+, 1=X-, 2=Y+, 3=Y-, 4=Z+, 5=Z-.

module pipa_counter_req #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WINDOW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PIPAXp,
  input  logic       PIPAXm,
  input  logic       PIPAYp,
  input  logic       PIPAYm,
  input  logic       PIPAZp,
  input  logic       PIPAZm,
  input  logic       CTACK,
  input  logic       FLCLR,
  output logic       CTREQ,
  output logic [1:0] CTAXIS,
  output logic       CTSIGN,
  output logic       PIPAFL,
  output logic       PIPOVF
);

  localparam int unsigned CntW = $clog2(WINDOW);

  logic [5:0]      raw;
  logic [5:0]      sync_q [SYNC_STAGES];
  logic [5:0]      hist_q;
  logic [5:0]      ev;

  logic [5:0]      pend_q, pend_d;
  logic [5:0]      ack_vec;
  logic [5:0]      avail;
  logic            accept;
  logic            held_live;
  logic            ovf_set;

  logic            ctreq_q, ctreq_d;
  logic [1:0]      axis_q, axis_d;
  logic            sign_q, sign_d;
  logic [1:0]      sel_axis;
  logic            sel_sign;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;
  logic            armed_q, armed_d;
  logic [2:0]      rec_p_q, rec_p_d;
  logic [2:0]      rec_m_q, rec_m_d;
  logic [2:0]      seen_p, seen_m;
  logic            fail_set;

  logic            fl_q, fl_d;
  logic            ovf_q, ovf_d;

  assign raw = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
  assign ev  = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Pending-bit update: the ack clears first, then events net against what is left,
  // so an ack racing an opposite-sign event leaves that event pending.
  always_comb begin
    accept  = ctreq_q & CTACK;
    ack_vec = '0;
    for (int i = 0; i < 6; i++) begin
      ack_vec[i] = accept && ({axis_q, sign_q} == 3'(i));
    end
    pend_d  = pend_q & ~ack_vec;
    ovf_set = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (ev[2*a] && !ev[2*a+1]) begin
        if (pend_d[2*a+1]) begin
          pend_d[2*a+1] = 1'b0;
        end else begin
          if (pend_d[2*a]) ovf_set = 1'b1;
          pend_d[2*a] = 1'b1;
        end
      end else if (ev[2*a+1] && !ev[2*a]) begin
        if (pend_d[2*a]) begin
          pend_d[2*a] = 1'b0;
        end else begin
          if (pend_d[2*a+1]) ovf_set = 1'b1;
          pend_d[2*a+1] = 1'b1;
        end
      end
    end
  end

  // Arbiter: only bits that survive this cycle are eligible, so a count cancelled
  // in the same cycle is never requested. X has priority over Y over Z.
  always_comb begin
    avail    = pend_q & pend_d;
    sel_axis = 2'd0;
    sel_sign = 1'b0;
    for (int a = 2; a >= 0; a--) begin
      if (avail[2*a] || avail[2*a+1]) begin
        sel_axis = 2'(a);
        sel_sign = avail[2*a+1];
      end
    end

    held_live = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ({axis_q, sign_q} == 3'(i)) held_live = pend_d[i];
    end

    ctreq_d = ctreq_q;
    axis_d  = axis_q;
    sign_d  = sign_q;
    if (ctreq_q) begin
      // Drop on accept, or withdraw when an opposite event cancelled the held count.
      if (accept || !held_live) ctreq_d = 1'b0;
    end else if (|avail) begin
      ctreq_d = 1'b1;
      axis_d  = sel_axis;
      sign_d  = sel_sign;
    end
  end

  // Fail check: each axis must see exactly one sign per window.
  always_comb begin
    wrap     = (cnt_q == CntW'(WINDOW - 1));
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    armed_d  = armed_q | wrap;
    fail_set = 1'b0;
    for (int a = 0; a < 3; a++) begin
      seen_p[a] = rec_p_q[a] | ev[2*a];
      seen_m[a] = rec_m_q[a] | ev[2*a+1];
      if (wrap && armed_q && (seen_p[a] == seen_m[a])) fail_set = 1'b1;
    end
    rec_p_d = wrap ? 3'b000 : seen_p;
    rec_m_d = wrap ? 3'b000 : seen_m;

    // A set in the same cycle as FLCLR wins.
    fl_d  = fail_set | (fl_q & ~FLCLR);
    ovf_d = ovf_set | (ovf_q & ~FLCLR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      ctreq_q <= 1'b0;
      axis_q  <= 2'd0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      rec_p_q <= '0;
      rec_m_q <= '0;
      fl_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q  <= sync_q[SYNC_STAGES-1];
      pend_q  <= pend_d;
      ctreq_q <= ctreq_d;
      axis_q  <= axis_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      rec_p_q <= rec_p_d;
      rec_m_q <= rec_m_d;
      fl_q    <= fl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign CTREQ  = ctreq_q;
  assign CTAXIS = axis_q;
  assign CTSIGN = sign_q;
  assign PIPAFL = fl_q;
  assign PIPOVF = ovf_q;

endmodule

// File: tb/tb_pipa_counter_req.sv
// Self-checking bench for pipa_counter_req: a per-cycle vector table for the
// single-pulse and priority cases, plus hand-written multi-cycle sequences.
// Raw vector bit order: 0=X+, 1=X-, 2=Y+, 3=Y-, 4=Z+, 5=Z-.

module tb_pipa_counter_req;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] raw = '0;
  logic       ctack = 1'b0;
  logic       flclr = 1'b0;
  logic       ctreq;
  logic [1:0] ctaxis;
  logic       ctsign;
  logic       pipafl;
  logic       pipovf;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  always #5 clk = ~clk;

  pipa_counter_req #(
    .SYNC_STAGES(2),
    .WINDOW     (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PIPAXp (raw[0]),
    .PIPAXm (raw[1]),
    .PIPAYp (raw[2]),
    .PIPAYm (raw[3]),
    .PIPAZp (raw[4]),
    .PIPAZm (raw[5]),
    .CTACK  (ctack),
    .FLCLR  (flclr),
    .CTREQ  (ctreq),
    .CTAXIS (ctaxis),
    .CTSIGN (ctsign),
    .PIPAFL (pipafl),
    .PIPOVF (pipovf)
  );

  typedef struct {
    logic [5:0] raw;
    logic       ack;
    logic       req;
    logic [1:0] axis;
    logic       sign;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hold reset, release it just after a posedge; the next posedge is edge 1.
  task automatic do_reset();
    rst   = 1'b1;
    raw   = '0;
    ctack = 1'b0;
    flclr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive inputs at the negedge, take one edge, sample 1 time unit later.
  task automatic step(input logic [5:0] r, input logic a, input logic c);
    @(negedge clk);
    raw   = r;
    ctack = a;
    flclr = c;
    if (ctreq && a) accepts++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Y+ single pulse, then X-/Y+/Z- together; CTACK held high.
    tbl[0]  = '{6'b000100, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{6'b000100, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{6'b000000, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[4]  = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{6'b100110, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{6'b100110, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{6'b000000, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{6'b000000, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{6'b000000, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[16] = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{6'b000000, 1'b1, 1'b0, 2'd0, 1'b0};

    // Reset state.
    do_reset();
    chk("reset_ctreq", 32'(ctreq), 32'd0);
    chk("reset_ctaxis", 32'(ctaxis), 32'd0);
    chk("reset_ctsign", 32'(ctsign), 32'd0);
    chk("reset_pipafl", 32'(pipafl), 32'd0);
    chk("reset_pipovf", 32'(pipovf), 32'd0);

    // Table-driven: latency, one-shot request, X>Y>Z priority with one-cycle gaps.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].raw, tbl[i].ack, 1'b0);
      chk($sformatf("vec%0d_ctreq", i), 32'(ctreq), 32'(tbl[i].req));
      if (tbl[i].req) begin
        chk($sformatf("vec%0d_ctaxis", i), 32'(ctaxis), 32'(tbl[i].axis));
        chk($sformatf("vec%0d_ctsign", i), 32'(ctsign), 32'(tbl[i].sign));
      end
      chk($sformatf("vec%0d_pipovf", i), 32'(pipovf), 32'd0);
      chk($sformatf("vec%0d_pipafl", i), 32'(pipafl), 32'd0);
    end

    // Withdrawal: Z+ requested, Z- cancels it without an ack.
    do_reset();
    accepts = 0;
    for (int e = 1; e <= 15; e++) begin
      logic [5:0] r;
      r = '0;
      if (e == 1 || e == 2) r = 6'b010000;
      if (e == 5 || e == 6) r = 6'b100000;
      step(r, 1'b0, 1'b0);
      if (e == 4) begin
        chk("wd_req_rise", 32'(ctreq), 32'd1);
        chk("wd_req_axis", 32'(ctaxis), 32'd2);
        chk("wd_req_sign", 32'(ctsign), 32'd0);
      end
      if (e == 6) chk("wd_req_held", 32'(ctreq), 32'd1);
      if (e >= 7) chk($sformatf("wd_req_low_e%0d", e), 32'(ctreq), 32'd0);
    end
    for (int e = 0; e < 4; e++) begin
      step('0, 1'b1, 1'b0);
      chk("wd_no_pending", 32'(ctreq), 32'd0);
    end
    chk("wd_accepts", 32'(accepts), 32'd0);
    chk("wd_pipovf", 32'(pipovf), 32'd0);

    // Overflow: two X+ events while the first is held unacknowledged.
    do_reset();
    accepts = 0;
    for (int e = 1; e <= 9; e++) begin
      logic [5:0] r;
      r = (e == 1 || e == 2 || e == 6 || e == 7) ? 6'b000001 : 6'b000000;
      step(r, 1'b0, 1'b0);
      if (e == 4) begin
        chk("ovf_req_rise", 32'(ctreq), 32'd1);
        chk("ovf_req_axis", 32'(ctaxis), 32'd0);
        chk("ovf_req_sign", 32'(ctsign), 32'd0);
      end
      if (e == 7) chk("ovf_before", 32'(pipovf), 32'd0);
      if (e == 8) chk("ovf_set", 32'(pipovf), 32'd1);
      if (e == 9) chk("ovf_req_held", 32'(ctreq), 32'd1);
    end
    for (int e = 10; e <= 16; e++) begin
      step('0, 1'b1, 1'b0);
      chk($sformatf("ovf_req_low_e%0d", e), 32'(ctreq), 32'd0);
    end
    chk("ovf_accepts", 32'(accepts), 32'd1);
    chk("ovf_sticky", 32'(pipovf), 32'd1);
    step('0, 1'b0, 1'b1);
    chk("ovf_flclr", 32'(pipovf), 32'd0);

    // Fail window: X+/Y+ every 8 cycles, Z+ only in the exempt first window.
    do_reset();
    for (int e = 1; e <= 62; e++) begin
      logic [5:0] r;
      r = '0;
      if ((e % 8) == 1 || (e % 8) == 2) begin
        r = 6'b000101;
        if (e <= 10) r[4] = 1'b1;
      end
      step(r, 1'b1, e == 62);
      if (e == 20) chk("fl_exempt_wrap", 32'(pipafl), 32'd0);
      if (e == 25) chk("fl_after_exempt", 32'(pipafl), 32'd0);
      if (e == 39) chk("fl_before_wrap2", 32'(pipafl), 32'd0);
      if (e == 40) chk("fl_set_wrap2", 32'(pipafl), 32'd1);
      if (e == 55) chk("fl_sticky", 32'(pipafl), 32'd1);
      if (e == 60) begin
        chk("fl_wrap3", 32'(pipafl), 32'd1);
        chk("fl_no_ovf", 32'(pipovf), 32'd0);
      end
      if (e == 62) chk("fl_flclr", 32'(pipafl), 32'd0);
    end

    // Reset while a Y+ request is held, Z+ pending and PIPOVF set.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      logic [5:0] r;
      r = '0;
      if (e == 1 || e == 2) r = 6'b010100;
      if (e == 6 || e == 7) r = 6'b000100;
      step(r, 1'b0, 1'b0);
      if (e == 4) begin
        chk("rst_req_rise", 32'(ctreq), 32'd1);
        chk("rst_req_axis", 32'(ctaxis), 32'd1);
      end
      if (e == 8) chk("rst_ovf_set", 32'(pipovf), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctreq", 32'(ctreq), 32'd0);
    chk("rst_async_ctaxis", 32'(ctaxis), 32'd0);
    chk("rst_async_ctsign", 32'(ctsign), 32'd0);
    chk("rst_async_pipafl", 32'(pipafl), 32'd0);
    chk("rst_async_pipovf", 32'(pipovf), 32'd0);
    raw = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step('0, 1'b1, 1'b0);
      chk($sformatf("rst_no_req_e%0d", e), 32'(ctreq), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
